branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: a table of 2-bit saturating counters indexed by PC bits, with a
// zero-latency prediction read and saturating branch and miss statistics counters.
module branch_predictor #(
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] predict_idx_i,
    output logic             predict_o,
    input  logic             update_valid_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             taken_i,
    input  logic             pred_taken_i,
    input  logic             stall_i,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_state_e;

    function automatic bp_state_e step_state(input bp_state_e cur, input logic taken);
        bp_state_e nxt;
        nxt = cur;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

    logic               upd_en;
    logic [ENTRIES-1:0] pred_vec;

    // A stalled branch is re-presented later, so it must leave no trace now.
    assign upd_en       = update_valid_i & ~stall_i;
    assign mispredict_o = update_valid_i & (taken_i ^ pred_taken_i);
    assign predict_o    = pred_vec[predict_idx_i];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            bp_state_e state_q;
            bp_state_e state_d;
            logic      hit;

            // upd_en gates the index compare so a floating index on idle cycles is harmless.
            assign hit = upd_en && (update_idx_i == IDX_W'(gi));

            always_comb begin
                state_d = state_q;
                if (hit) begin
                    state_d = step_state(state_q, taken_i);
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    state_q <= STRONG_T;
                end else begin
                    state_q <= state_d;
                end
            end

            assign pred_vec[gi] = state_q[1];
        end
    endgenerate

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_en) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (mispredict_o && (miss_cnt_q != CNT_MAX)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic checked against
// a confidence-level model (0..3) with unbounded event counts clipped on compare.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  predict_idx_i;
    logic        update_valid_i;
    logic [1:0]  update_idx_i;
    logic        taken_i;
    logic        pred_taken_i;
    logic        stall_i;
    logic        predict_o,  predict_s;
    logic        mispredict_o, mispredict_s;
    logic [15:0] branch_cnt_o, miss_cnt_o;
    logic [1:0]  branch_cnt_s, miss_cnt_s;

    int checks   = 0;
    int failures = 0;
    int model_tab[4];
    int n_branch;
    int n_miss;

    always #5 clk_i = ~clk_i;

    branch_predictor #(.IDX_W(2), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .predict_idx_i(predict_idx_i), .predict_o(predict_o),
        .update_valid_i(update_valid_i), .update_idx_i(update_idx_i), .taken_i(taken_i),
        .pred_taken_i(pred_taken_i), .stall_i(stall_i), .mispredict_o(mispredict_o),
        .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    branch_predictor #(.IDX_W(2), .CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .predict_idx_i(predict_idx_i), .predict_o(predict_s),
        .update_valid_i(update_valid_i), .update_idx_i(update_idx_i), .taken_i(taken_i),
        .pred_taken_i(pred_taken_i), .stall_i(stall_i), .mispredict_o(mispredict_s),
        .branch_cnt_o(branch_cnt_s), .miss_cnt_o(miss_cnt_s)
    );

    function automatic int sat(input int c, input int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_tab[i] = 3;
        n_branch = 0;
        n_miss   = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] idx, input logic t,
                         input logic p, input logic s, input logic [1:0] pidx);
        update_valid_i = v;
        update_idx_i   = idx;
        taken_i        = t;
        pred_taken_i   = p;
        stall_i        = s;
        predict_idx_i  = pidx;
        #1;
    endtask

    // Advance one clock; the model absorbs the update presented across that edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i && update_valid_i && !stall_i) begin
            int i;
            i = int'(update_idx_i);
            model_tab[i] = taken_i ? ((model_tab[i] < 3) ? model_tab[i] + 1 : 3)
                                   : ((model_tab[i] > 0) ? model_tab[i] - 1 : 0);
            n_branch++;
            if (taken_i != pred_taken_i) n_miss++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        model_reset();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int p = 0; p < 4; p++) begin
            predict_idx_i = 2'(p);
            #1;
            checks++;
            if (predict_o !== 1'b1) begin
                failures++;
                $display("FAIL reset_predict idx=%0d got=%b exp=1", p, predict_o);
            end
        end
        checks++;
        if (branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", branch_cnt_o, miss_cnt_o);
        end
        drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1);
        checks++;
        if (mispredict_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mispredict got=%b exp=1", mispredict_o);
        end
        tick();
        checks++;
        if (branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0 || predict_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard cnt=%0d/%0d pred=%b exp=0/0/1",
                     branch_cnt_o, miss_cnt_o, predict_o);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_i = 1'b1;
        #1;
    endtask

    task automatic test_train_not_taken();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1);
            tick();
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (predict_o !== 1'b0) begin
            failures++;
            $display("FAIL train_nt_predict got=%b exp=0", predict_o);
        end
        checks++;
        if (branch_cnt_o !== 16'd3 || miss_cnt_o !== 16'd3) begin
            failures++;
            $display("FAIL train_nt_counters got=%0d/%0d exp=3/3", branch_cnt_o, miss_cnt_o);
        end
        for (int p = 0; p < 4; p++) begin
            if (p == 1) continue;
            predict_idx_i = 2'(p);
            #1;
            checks++;
            if (predict_o !== 1'b1) begin
                failures++;
                $display("FAIL train_nt_other idx=%0d got=%b exp=1", p, predict_o);
            end
        end
    endtask

    task automatic test_recover();
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (predict_o !== 1'b0) begin
            failures++;
            $display("FAIL recover_weak_nt got=%b exp=0", predict_o);
        end
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1);
        checks++;
        if (predict_o !== 1'b1) begin
            failures++;
            $display("FAIL recover_weak_t got=%b exp=1", predict_o);
        end
        checks++;
        if (branch_cnt_o !== 16'd5 || miss_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL recover_counters got=%0d/%0d exp=5/5", branch_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_read_before_write();
        drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2);
        tick();
        drive(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2);
        checks++;
        if (predict_o !== 1'b1) begin
            failures++;
            $display("FAIL rbw_same_cycle got=%b exp=1", predict_o);
        end
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
        checks++;
        if (predict_o !== 1'b0) begin
            failures++;
            $display("FAIL rbw_next_cycle got=%b exp=0", predict_o);
        end
    endtask

    task automatic test_stall();
        logic [15:0] b0, m0;
        b0 = branch_cnt_o;
        m0 = miss_cnt_o;
        drive(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 2'd3);
        checks++;
        if (mispredict_o !== 1'b1) begin
            failures++;
            $display("FAIL stall_mispredict got=%b exp=1", mispredict_o);
        end
        tick();
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3);
        checks++;
        if (predict_o !== 1'b1 || branch_cnt_o !== b0 || miss_cnt_o !== m0) begin
            failures++;
            $display("FAIL stall_hold pred=%b cnt=%0d/%0d exp=1/%0d/%0d",
                     predict_o, branch_cnt_o, miss_cnt_o, b0, m0);
        end
        checks++;
        if (branch_cnt_o !== 16'(sat(n_branch, 65535))) begin
            failures++;
            $display("FAIL stall_model_branch got=%0d exp=%0d", branch_cnt_o, n_branch);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic v, t, p, s;
            logic [1:0] ui, pi;
            logic exp_pred, exp_mis;
            v  = 1'($urandom_range(0, 1));
            t  = 1'($urandom_range(0, 1));
            p  = 1'($urandom_range(0, 1));
            s  = ($urandom_range(0, 3) == 0);
            ui = 2'($urandom_range(0, 3));
            pi = ($urandom_range(0, 2) == 0) ? ui : 2'($urandom_range(0, 3));
            drive(v, ui, t, p, s, pi);
            exp_pred = (model_tab[int'(pi)] >= 2);
            exp_mis  = v && (t != p);
            checks++;
            if (predict_o !== exp_pred || predict_s !== exp_pred) begin
                failures++;
                $display("FAIL rand_predict k=%0d idx=%0d got=%b/%b exp=%b",
                         k, pi, predict_o, predict_s, exp_pred);
            end
            checks++;
            if (mispredict_o !== exp_mis || mispredict_s !== exp_mis) begin
                failures++;
                $display("FAIL rand_mispredict k=%0d got=%b/%b exp=%b",
                         k, mispredict_o, mispredict_s, exp_mis);
            end
            tick();
            checks++;
            if (branch_cnt_o !== 16'(sat(n_branch, 65535)) || miss_cnt_o !== 16'(sat(n_miss, 65535)) ||
                branch_cnt_s !== 2'(sat(n_branch, 3)) || miss_cnt_s !== 2'(sat(n_miss, 3))) begin
                failures++;
                $display("FAIL rand_counters k=%0d got=%0d/%0d small=%0d/%0d exp=%0d/%0d",
                         k, branch_cnt_o, miss_cnt_o, branch_cnt_s, miss_cnt_s, n_branch, n_miss);
            end
        end
    endtask

    task automatic test_saturation_and_reset();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_i = 1'b0;
        model_reset();
        #2;
        rst_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'(k % 4), 1'b0, 1'b1, 1'b0, 2'd0);
            tick();
        end
        checks++;
        if (branch_cnt_s !== 2'd3 || miss_cnt_s !== 2'd3) begin
            failures++;
            $display("FAIL sat_small got=%0d/%0d exp=3/3", branch_cnt_s, miss_cnt_s);
        end
        checks++;
        if (branch_cnt_o !== 16'd5 || miss_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL sat_wide got=%0d/%0d exp=5/5", branch_cnt_o, miss_cnt_o);
        end
        // Pulse reset mid-cycle with an update pending; everything must clear before the edge.
        drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (branch_cnt_o !== 16'd0 || miss_cnt_o !== 16'd0 ||
            branch_cnt_s !== 2'd0 || miss_cnt_s !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_counters got=%0d/%0d small=%0d/%0d exp=0",
                     branch_cnt_o, miss_cnt_o, branch_cnt_s, miss_cnt_s);
        end
        for (int p = 0; p < 4; p++) begin
            predict_idx_i = 2'(p);
            #1;
            checks++;
            if (predict_o !== 1'b1 || predict_s !== 1'b1) begin
                failures++;
                $display("FAIL async_reset_predict idx=%0d got=%b/%b exp=1", p, predict_o, predict_s);
            end
        end
        tick();
        rst_i = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        checks++;
        if (branch_cnt_o !== 16'd1 || miss_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL first_update_after_reset got=%0d/%0d exp=1/1", branch_cnt_o, miss_cnt_o);
        end
        drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        checks++;
        if (predict_o !== 1'b0 || model_tab[0] != 1) begin
            failures++;
            $display("FAIL post_reset_training got=%b exp=0", predict_o);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk_i);
        #1;
        test_reset();
        test_train_not_taken();
        test_recover();
        test_read_before_write();
        test_stall();
        test_random();
        test_saturation_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
